// File: rtl/uart_prog_loader_pkg.sv
// Shared constants and state encodings for the UART program loader.
package uart_prog_loader_pkg;

  localparam int       DATA_BITS      = 8;
  localparam logic     IDLE_LEVEL     = 1'b1;
  localparam int       BYTES_PER_WORD = 4;
  localparam int       COUNT_WIDTH    = 16;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    L_CNT_HI,
    L_CNT_LO,
    L_DATA,
    L_DONE
  } ld_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: rx synchroniser, baud counter and receive FSM.
module uart_rx_byte
  import uart_prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err_pulse
);

  localparam int                CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  FULL  = CNT_W'(CLKS_PER_BIT - 1);

  logic             r_sync1;
  logic             r_sync2;
  rx_state_t        r_state;
  rx_state_t        w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_stop_err;
  logic             r_byte_valid;
  logic             r_frame_err_pulse;
  logic             w_rx;

  assign w_rx            = r_sync2;
  assign byte_valid      = r_byte_valid;
  assign byte_data       = r_shift;
  assign frame_err_pulse = r_frame_err_pulse;

  // Two-flop synchroniser; resets to the line idle level so reset never looks like a start bit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= IDLE_LEVEL;
      r_sync2 <= IDLE_LEVEL;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  // Receiver state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= RX_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic: start-bit qualification at half a bit, then mid-bit sampling.
  always_comb begin
    w_next = r_state;
    case (r_state)
      RX_IDLE:  if (!w_rx) w_next = RX_START;
      RX_START: if (r_cnt == HALF) w_next = w_rx ? RX_IDLE : RX_DATA;
      RX_DATA:  if (r_cnt == FULL && r_bit_idx == 3'(DATA_BITS - 1)) w_next = RX_STOP;
      RX_STOP: begin
        if (r_stop_err) begin
          if (w_rx) w_next = RX_IDLE;
        end else if (r_cnt == FULL && w_rx) begin
          w_next = RX_IDLE;
        end
      end
      default:  w_next = RX_IDLE;
    endcase
  end

  // Baud counter, shift register and the one-cycle byte/frame-error strobes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt             <= '0;
      r_bit_idx         <= '0;
      r_shift           <= '0;
      r_stop_err        <= 1'b0;
      r_byte_valid      <= 1'b0;
      r_frame_err_pulse <= 1'b0;
    end else begin
      r_byte_valid      <= 1'b0;
      r_frame_err_pulse <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          r_cnt     <= '0;
          r_bit_idx <= '0;
        end
        RX_START: begin
          if (r_cnt == HALF) r_cnt <= '0;
          else               r_cnt <= r_cnt + CNT_W'(1);
        end
        RX_DATA: begin
          if (r_cnt == FULL) begin
            r_cnt     <= '0;
            r_shift   <= {w_rx, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (r_stop_err) begin
            if (w_rx) r_stop_err <= 1'b0;
          end else if (r_cnt == FULL) begin
            r_cnt <= '0;
            if (w_rx) begin
              r_byte_valid <= 1'b1;
            end else begin
              r_frame_err_pulse <= 1'b1;
              r_stop_err        <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

endmodule

// File: rtl/uart_prog_loader.sv
// Loads a program image from the UART into instruction memory, then releases the CPU.
module uart_prog_loader
  import uart_prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rx,
  output logic                  im_we,
  output logic [ADDR_WIDTH-1:0] im_addr,
  output logic [DATA_WIDTH-1:0] im_wdata,
  output logic                  do_system,
  output logic                  busy,
  output logic                  frame_err
);

  logic                   w_byte_valid;
  logic [7:0]             w_byte_data;
  logic                   w_frame_err_pulse;
  ld_state_t              r_state;
  ld_state_t              w_next;
  logic [COUNT_WIDTH-1:0] r_count;
  logic [COUNT_WIDTH-1:0] r_index;
  logic [1:0]             r_byte_cnt;
  logic [DATA_WIDTH-9:0]  r_word;
  logic                   r_word_strobe;
  logic                   r_im_we;
  logic [ADDR_WIDTH-1:0]  r_im_addr;
  logic [DATA_WIDTH-1:0]  r_im_wdata;
  logic                   r_busy;
  logic                   r_frame_err;
  logic [31:0]            w_idx_ext;
  logic                   w_overflow;
  logic                   w_last_byte;
  logic                   w_last_word;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clock          (clock),
    .reset          (reset),
    .rx             (rx),
    .byte_valid     (w_byte_valid),
    .byte_data      (w_byte_data),
    .frame_err_pulse(w_frame_err_pulse)
  );

  // Words past the memory depth are consumed but never written, and the address never wraps.
  assign w_idx_ext   = 32'(r_index);
  assign w_overflow  = (w_idx_ext >> ADDR_WIDTH) != 32'd0;
  assign w_last_byte = (r_state == L_DATA) && w_byte_valid &&
                       (r_byte_cnt == 2'(BYTES_PER_WORD - 1));
  assign w_last_word = r_word_strobe && ((r_index + COUNT_WIDTH'(1)) == r_count);

  assign im_we     = r_im_we;
  assign im_addr   = r_im_addr;
  assign im_wdata  = r_im_wdata;
  assign do_system = (r_state == L_DONE);
  assign busy      = r_busy && (r_state != L_DONE);
  assign frame_err = r_frame_err;

  // Loader state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= L_CNT_HI;
    else        r_state <= w_next;
  end

  // Next-state logic: big-endian word count header, then N words, then done forever.
  always_comb begin
    w_next = r_state;
    case (r_state)
      L_CNT_HI: if (w_byte_valid) w_next = L_CNT_LO;
      L_CNT_LO: if (w_byte_valid)
                  w_next = ({r_count[15:8], w_byte_data} == 16'd0) ? L_DONE : L_DATA;
      L_DATA:   if (w_last_word) w_next = L_DONE;
      L_DONE:   w_next = L_DONE;
      default:  w_next = L_CNT_HI;
    endcase
  end

  // Header capture, word assembly, write strobe and word index.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count       <= '0;
      r_index       <= '0;
      r_byte_cnt    <= '0;
      r_word        <= '0;
      r_word_strobe <= 1'b0;
      r_im_we       <= 1'b0;
      r_im_addr     <= '0;
      r_im_wdata    <= '0;
      r_busy        <= 1'b0;
    end else begin
      r_word_strobe <= w_last_byte;
      r_im_we       <= w_last_byte && !w_overflow;
      if (w_byte_valid && r_state != L_DONE) r_busy <= 1'b1;
      case (r_state)
        L_CNT_HI: if (w_byte_valid) r_count[15:8] <= w_byte_data;
        L_CNT_LO: if (w_byte_valid) r_count[7:0]  <= w_byte_data;
        L_DATA: begin
          if (w_byte_valid) begin
            r_word     <= {r_word[DATA_WIDTH-17:0], w_byte_data};
            r_byte_cnt <= r_byte_cnt + 2'd1;
          end
          if (w_last_byte) begin
            r_im_wdata <= {r_word, w_byte_data};
            if (!w_overflow) r_im_addr <= w_idx_ext[ADDR_WIDTH-1:0];
          end
          if (r_word_strobe) r_index <= r_index + COUNT_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  // Sticky frame-error flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                 r_frame_err <= 1'b0;
    else if (w_frame_err_pulse) r_frame_err <= 1'b1;
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench for uart_prog_loader: table vectors, corner sequences, random images.
`timescale 1ns/1ps
module tb_uart_prog_loader;

  localparam int CPB   = 16;
  // Small memory so that depth overflow is reachable in a short run.
  localparam int AW    = 3;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic          clock = 1'b0;
  logic          reset;
  logic          rx;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [DW-1:0] im_wdata;
  logic          do_system;
  logic          busy;
  logic          frame_err;

  uart_prog_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .rx       (rx),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .do_system(do_system),
    .busy     (busy),
    .frame_err(frame_err)
  );

  always #5 clock = ~clock;

  int cycleCnt = 0;
  always @(posedge clock) cycleCnt <= cycleCnt + 1;

  // Write capture and edge timestamps, sampled on the falling edge.
  int          capAddr[$];
  logic [31:0] capData[$];
  int          capCycle[$];
  int          doRise   = -1;
  int          busyFall = -1;
  logic        prevDo   = 1'b0;
  logic        prevBusy = 1'b0;

  always @(negedge clock) begin
    if (im_we === 1'b1) begin
      capAddr.push_back(int'(im_addr));
      capData.push_back(im_wdata);
      capCycle.push_back(cycleCnt);
    end
    if (do_system === 1'b1 && prevDo !== 1'b1) doRise = cycleCnt;
    if (busy === 1'b0 && prevBusy === 1'b1) busyFall = cycleCnt;
    prevDo   = do_system;
    prevBusy = busy;
  end

  int testsRun    = 0;
  int testsFailed = 0;

  logic [7:0]  txBytes[$];
  logic        txBad[$];
  int          lastStart;

  int          expAddr[$];
  logic [31:0] expData[$];
  logic        expDone;
  logic        expBusy;
  logic        expFerr;

  typedef struct packed {
    logic [95:0] seq;
    logic [11:0] bad;
    logic [3:0]  len;
    logic        glitch;
    logic [1:0]  expWrites;
    logic [31:0] expData0;
    logic [31:0] expData1;
    logic        expDone;
    logic        expBusy;
    logic        expFerr;
  } vec_t;

  vec_t vecs[5];
  vec_t v;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic sendBit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clock);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] b, input logic stopOk);
    lastStart = cycleCnt;
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(b[i]);
    sendBit(stopOk);
    rx = 1'b1;
    if (!stopOk) repeat (2 * CPB) @(posedge clock);
    else         repeat (4) @(posedge clock);
    #1;
  endtask

  task automatic clearCapture();
    capAddr.delete();
    capData.delete();
    capCycle.delete();
    doRise   = -1;
    busyFall = -1;
  endtask

  task automatic doReset();
    rx    = 1'b1;
    reset = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    clearCapture();
  endtask

  task automatic applyStimulus(input logic glitch);
    if (glitch) begin
      rx = 1'b0;
      repeat (4) @(posedge clock);
      #1;
      rx = 1'b1;
      repeat (40) @(posedge clock);
      #1;
    end
    foreach (txBytes[i]) sendByte(txBytes[i], !txBad[i]);
    repeat (3 * CPB) @(posedge clock);
    #1;
  endtask

  // Reference model: drop frame-errored bytes, read N, slice words, honour memory depth.
  task automatic modelImage();
    logic [7:0] good[$];
    int n;
    int avail;
    expAddr.delete();
    expData.delete();
    expFerr = 1'b0;
    foreach (txBytes[i]) begin
      if (txBad[i]) expFerr = 1'b1;
      else          good.push_back(txBytes[i]);
    end
    expDone = 1'b0;
    expBusy = (good.size() > 0);
    if (good.size() >= 2) begin
      n     = int'(good[0]) * 256 + int'(good[1]);
      avail = (good.size() - 2) / 4;
      for (int k = 0; k < n && k < avail; k++) begin
        if (k < DEPTH) begin
          expAddr.push_back(k);
          expData.push_back({good[2+4*k], good[3+4*k], good[4+4*k], good[5+4*k]});
        end
      end
      if (avail >= n) begin
        expDone = 1'b1;
        expBusy = 1'b0;
      end
    end
  endtask

  task automatic compareResults(input string tag);
    checkOutput({tag, " im_we count"}, 64'(capAddr.size()), 64'(expAddr.size()));
    for (int i = 0; i < expAddr.size() && i < capAddr.size(); i++) begin
      checkOutput($sformatf("%s addr[%0d]", tag, i), 64'(capAddr[i]), 64'(expAddr[i]));
      checkOutput($sformatf("%s data[%0d]", tag, i), 64'(capData[i]), 64'(expData[i]));
    end
    checkOutput({tag, " do_system"}, 64'(do_system), 64'(expDone));
    checkOutput({tag, " busy"},      64'(busy),      64'(expBusy));
    checkOutput({tag, " frame_err"}, 64'(frame_err), 64'(expFerr));
  endtask

  int          nWords;
  logic [7:0]  rb;

  initial begin
    reset = 1'b0;
    rx    = 1'b1;

    vecs[0] = '{seq: 96'h0002DEADBEEF123456780000, bad: 12'h000, len: 4'd10, glitch: 1'b0,
                expWrites: 2'd2, expData0: 32'hDEADBEEF, expData1: 32'h12345678,
                expDone: 1'b1, expBusy: 1'b0, expFerr: 1'b0};
    vecs[1] = '{seq: 96'h0000AA000000000000000000, bad: 12'h000, len: 4'd3, glitch: 1'b0,
                expWrites: 2'd0, expData0: 32'h0, expData1: 32'h0,
                expDone: 1'b1, expBusy: 1'b0, expFerr: 1'b0};
    vecs[2] = '{seq: 96'h000111223344000000000000, bad: 12'h000, len: 4'd6, glitch: 1'b1,
                expWrites: 2'd1, expData0: 32'h11223344, expData1: 32'h0,
                expDone: 1'b1, expBusy: 1'b0, expFerr: 1'b0};
    vecs[3] = '{seq: 96'h000155112233440000000000, bad: 12'h004, len: 4'd7, glitch: 1'b0,
                expWrites: 2'd1, expData0: 32'h11223344, expData1: 32'h0,
                expDone: 1'b1, expBusy: 1'b0, expFerr: 1'b1};
    vecs[4] = '{seq: 96'h000301020304050000000000, bad: 12'h000, len: 4'd7, glitch: 1'b0,
                expWrites: 2'd1, expData0: 32'h01020304, expData1: 32'h0,
                expDone: 1'b0, expBusy: 1'b1, expFerr: 1'b0};

    // Reset hold, then a long idle line.
    repeat (20) @(posedge clock);
    #1;
    checkOutput("reset outputs", 64'({im_we, im_addr, im_wdata, do_system, busy, frame_err}), 64'd0);
    reset = 1'b1;
    clearCapture();
    repeat (1000) @(posedge clock);
    #1;
    checkOutput("idle im_we count", 64'(capAddr.size()), 64'd0);
    checkOutput("idle outputs", 64'({im_we, im_addr, im_wdata, do_system, busy, frame_err}), 64'd0);

    // Table vectors with hand-written expectations.
    for (int t = 0; t < 5; t++) begin
      v = vecs[t];
      txBytes.delete();
      txBad.delete();
      for (int i = 0; i < int'(v.len); i++) begin
        txBytes.push_back(v.seq[95-8*i -: 8]);
        txBad.push_back(v.bad[i]);
      end
      expAddr.delete();
      expData.delete();
      if (v.expWrites >= 2'd1) begin expAddr.push_back(0); expData.push_back(v.expData0); end
      if (v.expWrites >= 2'd2) begin expAddr.push_back(1); expData.push_back(v.expData1); end
      expDone = v.expDone;
      expBusy = v.expBusy;
      expFerr = v.expFerr;
      doReset();
      applyStimulus(v.glitch);
      compareResults($sformatf("vec%0d", t));
      if (t == 0 && capCycle.size() == 2) begin
        checkOutput("vec0 do_system after last im_we", 64'(doRise - capCycle[1]), 64'd1);
        checkOutput("vec0 busy falls with do_system", 64'(busyFall), 64'(doRise));
        checkOutput("vec0 do_system latency window",
                    64'((doRise >= lastStart + (CPB * 19) / 2 + 3) &&
                        (doRise <= lastStart + (CPB * 19) / 2 + 7)), 64'd1);
      end
    end

    // Reset in the middle of the second data byte, then a clean reload.
    doReset();
    sendByte(8'h00, 1'b1);
    sendByte(8'h02, 1'b1);
    sendByte(8'hDE, 1'b1);
    checkOutput("midreset busy before", 64'(busy), 64'd1);
    sendBit(1'b0);
    for (int i = 0; i < 4; i++) sendBit(rb[0] ^ 1'b1 ^ 1'b1 | 1'b1);
    reset = 1'b0;
    #1;
    checkOutput("midreset outputs", 64'({im_we, im_addr, im_wdata, do_system, busy, frame_err}), 64'd0);
    rx = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    clearCapture();
    txBytes = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78};
    txBad   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    applyStimulus(1'b0);
    modelImage();
    compareResults("reload");

    // Depth overflow: nine words into an eight-word memory.
    txBytes.delete();
    txBad.delete();
    txBytes.push_back(8'h00);
    txBytes.push_back(8'h09);
    txBad.push_back(1'b0);
    txBad.push_back(1'b0);
    for (int k = 0; k < 9; k++) begin
      for (int j = 0; j < 4; j++) begin
        txBytes.push_back(8'(16 * k + j + 1));
        txBad.push_back(1'b0);
      end
    end
    doReset();
    applyStimulus(1'b0);
    modelImage();
    compareResults("overflow");
    checkOutput("overflow last addr", 64'(im_addr), 64'(DEPTH - 1));

    // Random images with occasional frame-errored bytes.
    for (int t = 0; t < 5; t++) begin
      nWords = $urandom_range(0, 10);
      txBytes.delete();
      txBad.delete();
      for (int i = 0; i < 2 + 4 * nWords; i++) begin
        if (i == 0)      rb = 8'(nWords >> 8);
        else if (i == 1) rb = 8'(nWords);
        else             rb = 8'($urandom);
        if ($urandom_range(0, 9) == 0) begin
          txBytes.push_back(8'($urandom));
          txBad.push_back(1'b1);
        end
        txBytes.push_back(rb);
        txBad.push_back(1'b0);
      end
      doReset();
      applyStimulus(1'b0);
      modelImage();
      compareResults($sformatf("rand%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
